// File: rtl/decodificador_gray_pkg.sv
// Shared constants and pure conversion functions for the binary/Gray converter.
// Functions work on 32-bit words; callers zero-extend narrower words and truncate the result.
package decodificador_gray_pkg;

    localparam int   DEFAULT_WIDTH = 4;
    localparam int   MAX_WIDTH     = 32;
    localparam logic MODO_BIN2GRAY = 1'b0;
    localparam logic MODO_GRAY2BIN = 1'b1;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave narrower words unaffected.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_hamming_check.sv
// Flags when two Gray words differ in more than one bit position.
module gray_hamming_check #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] curr_i,
    output logic             too_far_o
);

    logic [WIDTH-1:0] diff;
    logic [5:0]       ones;

    always_comb begin
        diff = prev_i ^ curr_i;
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + 6'(diff[i]);
        end
        too_far_o = (ones > 6'd1);
    end

endmodule

// File: rtl/decodificador_binario_gray.sv
// Registered binary<->Gray converter with a one-cycle valid strobe.
// Optional sticky step checker enabled by DECODIFICADOR_GRAY_STEP_CHECK_EN.
module decodificador_binario_gray
    import decodificador_gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             modo,
    input  logic [WIDTH-1:0] Binario,
    output logic [WIDTH-1:0] Gray,
`ifdef DECODIFICADOR_GRAY_STEP_CHECK_EN
    output logic             step_err,
`endif
    output logic             valido
);

    logic [WIDTH-1:0]     gray_q;
    logic [WIDTH-1:0]     gray_d;
    logic                 valido_q;
    logic [MAX_WIDTH-1:0] word_ext;
    logic [WIDTH-1:0]     conv_word;

    always_comb begin
        word_ext  = MAX_WIDTH'(Binario);
        conv_word = (modo == MODO_GRAY2BIN) ? WIDTH'(gray2bin(word_ext))
                                            : WIDTH'(bin2gray(word_ext));
        gray_d    = en ? conv_word : gray_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q   <= '0;
            valido_q <= 1'b0;
        end else begin
            gray_q   <= gray_d;
            valido_q <= en;
        end
    end

    assign Gray   = gray_q;
    assign valido = valido_q;

`ifdef DECODIFICADOR_GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] hist_q;
    logic             hist_valid_q;
    logic             step_err_q;
    logic             too_far;

    gray_hamming_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .prev_i    (hist_q),
        .curr_i    (conv_word),
        .too_far_o (too_far)
    );

    // Only binary-to-Gray samples form the checked sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q       <= '0;
            hist_valid_q <= 1'b0;
            step_err_q   <= 1'b0;
        end else if (en && (modo == MODO_BIN2GRAY)) begin
            hist_q       <= conv_word;
            hist_valid_q <= 1'b1;
            if (hist_valid_q && too_far) begin
                step_err_q <= 1'b1;
            end
        end
    end

    assign step_err = step_err_q;
`endif

endmodule

// File: tb/tb_decodificador_binario_gray.sv
// Self-checking bench for decodificador_binario_gray (WIDTH=4), both build variants.
module tb_decodificador_binario_gray;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         modo = 1'b0;
    logic [W-1:0] Binario = '0;
    logic [W-1:0] Gray;
    logic         valido;
`ifdef DECODIFICADOR_GRAY_STEP_CHECK_EN
    logic         step_err;
`endif

    always #5 clk = ~clk;

    decodificador_binario_gray #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .modo     (modo),
        .Binario  (Binario),
        .Gray     (Gray),
`ifdef DECODIFICADOR_GRAY_STEP_CHECK_EN
        .step_err (step_err),
`endif
        .valido   (valido)
    );

    typedef struct {
        logic [W-1:0] g;
        logic         v;
        logic         e;
        string        tag;
    } exp_t;

    typedef struct {
        logic         md;
        logic [W-1:0] b;
        logic [W-1:0] g;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[10];

    int total = 0;
    int passed = 0;

    // Reference model of the step checker
    logic [W-1:0] m_hist;
    logic         m_hist_v;
    logic         m_err;

    function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = W - 2; i >= 0; i--) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    function automatic int popcnt(input logic [W-1:0] x);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(x[i]);
        return n;
    endfunction

    task automatic model_reset();
        m_hist   = '0;
        m_hist_v = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_step(input string name, input logic exp);
`ifdef DECODIFICADOR_GRAY_STEP_CHECK_EN
        check(name, 32'(step_err), 32'(exp));
`endif
    endtask

    // Drive one cycle; xg is the Gray value expected after the edge.
    task automatic drive(input logic e, input logic md, input logic [W-1:0] b,
                         input logic [W-1:0] xg, input string tag);
        exp_t x;
        @(negedge clk);
        en = e; modo = md; Binario = b;
        if (e && !md) begin
            if (m_hist_v && popcnt(m_hist ^ xg) > 1) m_err = 1'b1;
            m_hist   = xg;
            m_hist_v = 1'b1;
        end
        sb.push_back('{g: xg, v: e, e: m_err, tag: tag});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({x.tag, ".gray"}, 32'(Gray), 32'(x.g));
        check({x.tag, ".valido"}, 32'(valido), 32'(x.v));
        check_step({x.tag, ".step_err"}, x.e);
        $display("txn %-10s en=%0b modo=%0b in=%b -> Gray=%b valido=%0b", x.tag, e, md, b, Gray, valido);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b0, 4'b0101, 4'b0111};
        tbl[1] = '{1'b0, 4'b0110, 4'b0101};
        tbl[2] = '{1'b0, 4'b1000, 4'b1100};
        tbl[3] = '{1'b0, 4'b1101, 4'b1011};
        tbl[4] = '{1'b0, 4'b1110, 4'b1001};
        tbl[5] = '{1'b0, 4'b1111, 4'b1000};
        tbl[6] = '{1'b1, 4'b0111, 4'b0101};
        tbl[7] = '{1'b1, 4'b1100, 4'b1000};
        tbl[8] = '{1'b1, 4'b1000, 4'b1111};
        tbl[9] = '{1'b1, 4'b1011, 4'b1101};
        model_reset();

        // Reset held with en toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en = ~en;
            modo = 1'b0;
            Binario = W'($urandom);
            @(posedge clk);
            #1;
            check("rst.gray", 32'(Gray), 32'h0);
            check("rst.valido", 32'(valido), 32'h0);
            check_step("rst.step_err", 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, "first0");

        // Table, back-to-back
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].md, tbl[i].b, tbl[i].g, $sformatf("tbl%0d", i));
        end

        // Round trip all values through both directions
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] v;
            v = W'(i);
            drive(1'b1, 1'b0, v, m_b2g(v), $sformatf("rt_b2g%0d", i));
            drive(1'b1, 1'b1, m_b2g(v), v, $sformatf("rt_g2b%0d", i));
        end

        // Hold while en=0
        drive(1'b1, 1'b0, 4'b0011, 4'b0010, "hold_acc");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'($urandom), W'($urandom), 4'b0010, $sformatf("hold%0d", i));
        end

        // Async reset between edges clears outputs immediately
        drive(1'b1, 1'b0, 4'b1111, 4'b1000, "pre_arst");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.gray", 32'(Gray), 32'h0);
        check("arst.valido", 32'(valido), 32'h0);
        check_step("arst.step_err", 1'b0);
        $display("txn arst       Gray=%b valido=%0b", Gray, valido);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        model_reset();

        // In-flight sample discarded by reset
        @(negedge clk);
        en = 1'b1; modo = 1'b0; Binario = 4'b1111;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("inflight.gray", 32'(Gray), 32'h0);
        check("inflight.valido", 32'(valido), 32'h0);
        $display("txn inflight   Gray=%b valido=%0b", Gray, valido);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        model_reset();

        // Step sequence: distances 1,0,1,1, a modo=1 sample, then 1, then 2
        drive(1'b1, 1'b0, 4'b0101, 4'b0111, "step0");
        drive(1'b1, 1'b0, 4'b0110, 4'b0101, "step1");
        drive(1'b1, 1'b0, 4'b0110, 4'b0101, "step2");
        drive(1'b1, 1'b0, 4'b0101, 4'b0111, "step3");
        drive(1'b1, 1'b0, 4'b0100, 4'b0110, "step4");
        drive(1'b1, 1'b1, 4'b1111, 4'b1010, "step_g2b");
        drive(1'b1, 1'b0, 4'b1011, 4'b1110, "step5");
        check_step("step_ok_before_jump", 1'b0);
        drive(1'b1, 1'b0, 4'b1101, 4'b1011, "step_jump");
        check_step("step_err_set", 1'b1);
        drive(1'b1, 1'b0, 4'b1100, 4'b1010, "step_sticky");
        drive(1'b0, 1'b0, 4'b0000, 4'b1010, "step_idle");

        // Async reset then a far first sample must not flag
        #2;
        rst_n = 1'b0;
        #1;
        check_step("step_arst_clear", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        model_reset();
        drive(1'b1, 1'b0, 4'b1111, 4'b1000, "post_first");
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, "post_next");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
